// File: rtl/spi_led_regs.sv
// rtl/spi_led_regs.sv - SPI mode-0 slave holding a 16-bit LED frame register.
`timescale 1ns/1ps
module spi_led_regs #(
    parameter logic [15:0] RESET_LEDS  = 16'h0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_cs,
    input  logic        cfg_sck,
    input  logic        cfg_si,
    output logic        cfg_so,
    output logic        so_oe,
    output logic [15:0] ledbits,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SET   = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;
    localparam logic [7:0] CMD_READ  = 8'h80;

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    logic [SYNC_STAGES-1:0] cs_sr, sck_sr, si_sr;
    logic [SYNC_STAGES:0]   prime;
    logic                   cs_d, sck_d;
    logic                   cs_s, sck_s, si_s, ready;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] shift, shift_n;
    logic [7:0]  cmd, cmd_n;
    logic [15:0] rd_sr, rd_n;
    logic [15:0] led_n;
    logic        so_n, done_n, err_n;
    logic [15:0] data_w;
    logic [7:0]  cmd_w;

    assign cs_s  = cs_sr[SYNC_STAGES-1];
    assign sck_s = sck_sr[SYNC_STAGES-1];
    assign si_s  = si_sr[SYNC_STAGES-1];
    // Edges are ignored until the synchronisers hold real pin values, so a
    // frame already in progress when reset releases is not mistaken for a start.
    assign ready = prime[SYNC_STAGES];

    assign cs_fall  = ready &  cs_d  & ~cs_s;
    assign cs_rise  = ready & ~cs_d  &  cs_s;
    assign sck_rise = ready & ~sck_d &  sck_s;
    assign sck_fall = ready &  sck_d & ~sck_s;

    assign so_oe = ~cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sr  <= '1;
            sck_sr <= '0;
            si_sr  <= '0;
            prime  <= '0;
            cs_d   <= 1'b1;
            sck_d  <= 1'b0;
        end else begin
            cs_sr  <= {cs_sr[SYNC_STAGES-2:0], cfg_cs};
            sck_sr <= {sck_sr[SYNC_STAGES-2:0], cfg_sck};
            si_sr  <= {si_sr[SYNC_STAGES-2:0], cfg_si};
            prime  <= {prime[SYNC_STAGES-1:0], 1'b1};
            cs_d   <= cs_s;
            sck_d  <= sck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            cmd        <= '0;
            rd_sr      <= '0;
            ledbits    <= RESET_LEDS;
            cfg_so     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            cmd        <= cmd_n;
            rd_sr      <= rd_n;
            ledbits    <= led_n;
            cfg_so     <= so_n;
            frame_done <= done_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        cmd_n   = cmd;
        rd_n    = rd_sr;
        led_n   = ledbits;
        so_n    = cfg_so;
        done_n  = 1'b0;
        err_n   = 1'b0;
        data_w  = {shift[14:0], si_s};
        cmd_w   = {shift[6:0], si_s};

        if (cs_fall) begin
            state_n = CMD;
            cnt_n   = '0;
            shift_n = '0;
            so_n    = 1'b0;
        end else begin
            case (state)
                IDLE: so_n = 1'b0;
                CMD: begin
                    if (cs_rise) begin
                        state_n = IDLE;
                        err_n   = (cnt != 5'd0);
                    end else if (sck_rise) begin
                        shift_n = data_w;
                        cnt_n   = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cmd_n   = cmd_w;
                            state_n = DATA;
                            // READ presents bit 15 right away; the host samples it on rise 9
                            if (cmd_w == CMD_READ) begin
                                so_n = ledbits[15];
                                rd_n = {ledbits[14:0], 1'b0};
                            end
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        so_n    = 1'b0;
                    end else if (sck_rise) begin
                        shift_n = data_w;
                        cnt_n   = cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            state_n = HOLD;
                            done_n  = 1'b1;
                            so_n    = 1'b0;
                            case (cmd)
                                CMD_WRITE: led_n = data_w;
                                CMD_SET:   led_n = ledbits | data_w;
                                CMD_CLEAR: led_n = ledbits & ~data_w;
                                default:   led_n = ledbits;
                            endcase
                        end
                    end else if (sck_fall && cmd == CMD_READ && cnt > 5'd8) begin
                        so_n = rd_sr[15];
                        rd_n = {rd_sr[14:0], 1'b0};
                    end
                end
                HOLD: begin
                    so_n = 1'b0;
                    if (cs_rise)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_led_regs.sv
// tb/tb_spi_led_regs.sv - scoreboard bench for spi_led_regs driven as an SPI host.
`timescale 1ns/1ps
module tb_spi_led_regs;

    localparam logic [15:0] RST_LEDS = 16'hC3A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_cs = 1'b1;
    logic        cfg_sck = 1'b0;
    logic        cfg_si = 1'b0;
    logic        cfg_so, so_oe, frame_done, frame_err;
    logic [15:0] ledbits;

    always #5 clk = ~clk;

    spi_led_regs #(.RESET_LEDS(RST_LEDS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_cs     (cfg_cs),
        .cfg_sck    (cfg_sck),
        .cfg_si     (cfg_si),
        .cfg_so     (cfg_so),
        .so_oe      (so_oe),
        .ledbits    (ledbits),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_led;
    logic [15:0] prev_led;
    logic        prev_done, prev_err;
    int          n_done = 0, n_err = 0;
    int          exp_done = 0, exp_err = 0;
    int          oe_bad = 0;
    logic [31:0] rx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        model_led = RST_LEDS;
        prev_done = 1'b0;
        prev_err  = 1'b0;
        prev_led  = RST_LEDS;
        forever begin
            @(negedge clk);
            if (rst)
                model_led = RST_LEDS;
            if (frame_done) begin
                check_eq("done_width", {31'd0, prev_done}, 32'd0);
                check_eq("done_err_excl", {31'd0, frame_err}, 32'd0);
                n_done++;
                check_eq("sb_empty_on_done", {31'd0, exp_q.size() == 0}, 32'd0);
                if (exp_q.size() != 0) begin
                    check_eq("led_before_done", {16'd0, prev_led}, {16'd0, model_led});
                    model_led = exp_q.pop_front();
                    check_eq("led_at_done", {16'd0, ledbits}, {16'd0, model_led});
                end
            end
            if (frame_err) begin
                check_eq("err_width", {31'd0, prev_err}, 32'd0);
                n_err++;
            end
            prev_done = frame_done;
            prev_err  = frame_err;
            prev_led  = ledbits;
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_low();
        cfg_cs = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        cfg_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n, output logic [31:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            cfg_si = val[i];
            half();
            r = {r[30:0], cfg_so};
            if (!so_oe) oe_bad++;
            cfg_sck = 1'b1;
            half();
            cfg_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [15:0] d, input logic [15:0] exp_led);
        logic [31:0] r;
        exp_q.push_back(exp_led);
        exp_done++;
        cs_low();
        shift_bits({8'd0, c, d}, 24, r);
        cs_high();
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        check_eq("rst_led", {16'd0, ledbits}, {16'd0, RST_LEDS});
        check_eq("rst_so", {31'd0, cfg_so}, 32'd0);
        check_eq("rst_oe", {31'd0, so_oe}, 32'd0);
        check_eq("rst_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        frame(8'h01, 16'hA55A, 16'hA55A);
        check_eq("write_done_cnt", n_done, exp_done);
        check_eq("write_led", {16'd0, ledbits}, 32'h0000_A55A);

        frame(8'h01, 16'h00F0, 16'h00F0);
        frame(8'h02, 16'h0F00, 16'h0FF0);
        check_eq("set_led", {16'd0, ledbits}, 32'h0000_0FF0);
        frame(8'h03, 16'h00F0, 16'h0F00);
        check_eq("clear_led", {16'd0, ledbits}, 32'h0000_0F00);
        check_eq("setclr_done_cnt", n_done, exp_done);

        frame(8'h01, 16'h1234, 16'h1234);
        exp_q.push_back(16'h1234);
        exp_done++;
        oe_bad = 0;
        cs_low();
        shift_bits({8'd0, 8'h80, 16'($urandom)}, 24, rx);
        check_eq("read_oe_cs_low", {31'd0, so_oe}, 32'd1);
        cs_high();
        check_eq("read_data", rx, 32'h0000_1234);
        check_eq("read_oe", oe_bad, 0);
        check_eq("read_oe_cs_high", {31'd0, so_oe}, 32'd0);
        check_eq("read_led", {16'd0, ledbits}, 32'h0000_1234);

        exp_err++;
        cs_low();
        shift_bits({14'd0, 8'h01, 10'h3FF}, 18, rx);
        cs_high();
        check_eq("abort_err_cnt", n_err, exp_err);
        check_eq("abort_led", {16'd0, ledbits}, 32'h0000_1234);
        cs_low();
        cs_high();
        check_eq("silent_err_cnt", n_err, exp_err);
        frame(8'h01, 16'hFFFF, 16'hFFFF);
        check_eq("after_abort_led", {16'd0, ledbits}, 32'h0000_FFFF);

        exp_q.push_back(16'h0001);
        exp_done++;
        cs_low();
        shift_bits({8'h01, 16'h0001, 8'hFF}, 32, rx);
        cs_high();
        check_eq("overrun_led", {16'd0, ledbits}, 32'h0000_0001);
        check_eq("overrun_done_cnt", n_done, exp_done);
        frame(8'h55, 16'hBEEF, 16'h0001);
        check_eq("unknown_led", {16'd0, ledbits}, 32'h0000_0001);

        cs_low();
        shift_bits(32'h0000_0017, 12, rx);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_led", {16'd0, ledbits}, {16'd0, RST_LEDS});
        check_eq("midrst_so", {31'd0, cfg_so}, 32'd0);
        rst = 1'b0;
        shift_bits(32'h0000_0777, 12, rx);
        cs_high();
        check_eq("midrst_led_after", {16'd0, ledbits}, {16'd0, RST_LEDS});
        check_eq("midrst_done_cnt", n_done, exp_done);
        check_eq("midrst_err_cnt", n_err, exp_err);
        frame(8'h01, 16'h0003, 16'h0003);
        check_eq("fresh_led", {16'd0, ledbits}, 32'h0000_0003);
        check_eq("final_done_cnt", n_done, exp_done);
        check_eq("final_err_cnt", n_err, exp_err);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
